fifo_rd_packer: RTL and testbench

//  Read-side consumer of asyn_fifo. Runs in the rclk domain: pops words when rempty=0 and

---
 rtl/fifo_rd_packer.sv | 186 ++++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer of a show-ahead asynchronous FIFO, living entirely in the
// read clock domain. It pops FIFO words whenever it can and packs PACK
// consecutive WIDTH-bit words into one wide beat. The beat is offered on a
// valid/ready stream. A flush request emits a partial beat. The block also
// checks that the writer's data follows an incrementing pattern (mod 2^WIDTH).
//
// Ports
//   rclk        in   read clock
//   rrst_n      in   asynchronous active-low reset
//   rdata       in   FIFO head word, valid whenever rempty=0
//   rempty      in   FIFO empty flag
//   rinc        out  pop strobe; FIFO advances on the rclk edge when high
//   out_data    out  packed beat, first-popped word in the LSBs
//   out_words   out  number of valid words in out_data
//   out_valid   out  out_data/out_words valid
//   out_ready   in   downstream accepts the beat when out_valid & out_ready
//   flush       in   single-cycle request to emit a partial beat
//   seq_chk_en  in   enable for the incrementing-pattern check
//   seq_err     out  sticky pattern-mismatch flag
//   err_cnt     out  saturating mismatch counter
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int PACK  = 4,
    parameter int CNT_W = 16
) (
    input  logic                       rclk,
    input  logic                       rrst_n,
    input  logic [WIDTH-1:0]           rdata,
    input  logic                       rempty,
    output logic                       rinc,
    output logic [WIDTH*PACK-1:0]      out_data,
    output logic [$clog2(PACK+1)-1:0]  out_words,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       seq_chk_en,
    output logic                       seq_err,
    output logic [CNT_W-1:0]           err_cnt
);

    localparam int LANE_W  = $clog2(PACK);
    localparam int WORDS_W = $clog2(PACK + 1);
    localparam int BEAT_W  = WIDTH * PACK;

    localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(PACK - 1);
    localparam logic [WORDS_W-1:0] FULL_WORDS = WORDS_W'(PACK);

    // State
    logic [LANE_W-1:0]  cnt_q,        cnt_d;
    logic [BEAT_W-1:0]  acc_q,        acc_d;
    logic [BEAT_W-1:0]  out_data_q,   out_data_d;
    logic [WORDS_W-1:0] out_words_q,  out_words_d;
    logic               out_valid_q,  out_valid_d;
    logic               flush_pend_q, flush_pend_d;
    logic               run_q,        run_d;
    logic               first_seen_q, first_seen_d;
    logic [WIDTH-1:0]   exp_q,        exp_d;
    logic               seq_err_q,    seq_err_d;
    logic [CNT_W-1:0]   err_cnt_q,    err_cnt_d;

    // Handshake / pop qualification
    logic out_free;
    logic last_lane;
    logic can_acc;
    logic pop;

    // The output register is free when empty or being drained this cycle.
    assign out_free  = !out_valid_q || out_ready;
    assign last_lane = (cnt_q == LAST_LANE);
    // Only the completing pop needs the output register; the lower lanes can
    // keep filling while a beat is stalled downstream.
    assign can_acc   = !last_lane || out_free;
    // run_q is zero in reset and for the first edge after release, so no pop
    // is requested before the block has seen a clean clock edge.
    assign pop       = run_q && !rempty && !flush_pend_q && can_acc;

    assign rinc      = pop;
    assign out_data  = out_data_q;
    assign out_words = out_words_q;
    assign out_valid = out_valid_q;
    assign seq_err   = seq_err_q;
    assign err_cnt   = err_cnt_q;

    // NOTE: every variable gets its hold value first so no path through the
    // branches below can leave one unassigned and infer a latch.
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_words_d  = out_words_q;
        out_valid_d  = out_valid_q;
        flush_pend_d = flush_pend_q;
        run_d        = 1'b1;
        first_seen_d = first_seen_q;
        exp_d        = exp_q;
        seq_err_d    = seq_err_q;
        err_cnt_d    = err_cnt_q;

        // Accepted beat drops valid; a load below overrides this so an
        // accept and a new load on the same edge leave valid high.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (pop) begin
            if (last_lane) begin
                out_data_d  = {rdata, acc_q[BEAT_W-WIDTH-1:0]};
                out_words_d = FULL_WORDS;
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
            end else begin
                acc_d[int'(cnt_q)*WIDTH +: WIDTH] = rdata;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Pops are blocked while a flush is pending, so this never collides
        // with the pop path above.
        if (flush_pend_q && out_free) begin
            if (cnt_q != '0) begin
                out_data_d  = acc_q;
                out_words_d = WORDS_W'(cnt_q);
                out_valid_d = 1'b1;
                cnt_d       = '0;
                acc_d       = '0;
            end
            flush_pend_d = 1'b0;
        end

        // A request arriving while one is already pending is absorbed.
        if (flush && !flush_pend_q) begin
            flush_pend_d = 1'b1;
        end

        // Pattern check resynchronises on every popped word, so one bad word
        // costs exactly one error and wrap from all-ones to zero is legal.
        if (!seq_chk_en) begin
            first_seen_d = 1'b0;
        end else if (pop) begin
            if (first_seen_q && (rdata != exp_q)) begin
                seq_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
            exp_d        = rdata + 1'b1;
            first_seen_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_words_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_pend_q <= 1'b0;
            run_q        <= 1'b0;
            first_seen_q <= 1'b0;
            exp_q        <= '0;
            seq_err_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_words_q  <= out_words_d;
            out_valid_q  <= out_valid_d;
            flush_pend_q <= flush_pend_d;
            run_q        <= run_d;
            first_seen_q <= first_seen_d;
            exp_q        <= exp_d;
            seq_err_q    <= seq_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Bench for fifo_rd_packer (WIDTH=8, PACK=4). A queue models the show-ahead
// FIFO; every pushed word also feeds a small packing model that queues the
// expected beats, which a monitor pops and compares as the DUT hands them off.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

    localparam int WIDTH = 8;
    localparam int PACK  = 4;
    localparam int CNT_W = 16;
    localparam int OW    = $clog2(PACK + 1);
    localparam int BW    = WIDTH * PACK;

    logic             rclk       = 1'b0;
    logic             rrst_n     = 1'b0;
    logic [WIDTH-1:0] rdata      = '0;
    logic             rempty     = 1'b1;
    logic             rinc;
    logic [BW-1:0]    out_data;
    logic [OW-1:0]    out_words;
    logic             out_valid;
    logic             out_ready  = 1'b0;
    logic             flush      = 1'b0;
    logic             seq_chk_en = 1'b0;
    logic             seq_err;
    logic [CNT_W-1:0] err_cnt;

    fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .CNT_W(CNT_W)) dut (
        .rclk       (rclk),
        .rrst_n     (rrst_n),
        .rdata      (rdata),
        .rempty     (rempty),
        .rinc       (rinc),
        .out_data   (out_data),
        .out_words  (out_words),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .flush      (flush),
        .seq_chk_en (seq_chk_en),
        .seq_err    (seq_err),
        .err_cnt    (err_cnt)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [BW-1:0] data;
        logic [OW-1:0] words;
    } beat_t;

    beat_t            exp_q[$];
    logic [WIDTH-1:0] fifo_q[$];
    logic [BW-1:0]    m_acc = '0;
    int               m_cnt = 0;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int beats  = 0;
    logic pop_now = 1'b0;

    // ---------------- FIFO model ----------------
    task automatic refresh();
        rempty = (fifo_q.size() == 0);
        rdata  = rempty ? '0 : fifo_q[0];
    endtask

    always @(negedge rclk) pop_now = (rinc === 1'b1);

    always @(posedge rclk) begin
        #1;
        if (pop_now) begin
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            pops++;
            pop_now = 1'b0;
        end
        refresh();
    end

    // ---------------- packing model / scoreboard producer ----------------
    task automatic push_word(input logic [WIDTH-1:0] w);
        beat_t b;
        fifo_q.push_back(w);
        m_acc[m_cnt*WIDTH +: WIDTH] = w;
        m_cnt++;
        if (m_cnt == PACK) begin
            b.data  = m_acc;
            b.words = OW'(PACK);
            exp_q.push_back(b);
            m_acc = '0;
            m_cnt = 0;
        end
        refresh();
    endtask

    task automatic model_flush();
        beat_t b;
        if (m_cnt > 0) begin
            b.data  = m_acc;
            b.words = OW'(m_cnt);
            exp_q.push_back(b);
        end
        m_acc = '0;
        m_cnt = 0;
    endtask

    task automatic model_clear();
        exp_q.delete();
        fifo_q.delete();
        m_acc = '0;
        m_cnt = 0;
        refresh();
    endtask

    // ---------------- monitor ----------------
    logic          prev_hold  = 1'b0;
    logic [BW-1:0] prev_data  = '0;
    logic [OW-1:0] prev_words = '0;

    always @(negedge rclk) begin
        beat_t e;
        if (rrst_n !== 1'b1) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checks++;
                if (out_data !== prev_data || out_words !== prev_words) begin
                    errors++;
                    $display("FAIL hold_stable: got %h/%0d expected %h/%0d",
                             out_data, out_words, prev_data, prev_words);
                end
            end
            prev_hold  = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_data  = out_data;
            prev_words = out_words;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got %h/%0d expected none",
                             out_data, out_words);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.data || out_words !== e.words) begin
                        errors++;
                        $display("FAIL beat: got %h/%0d expected %h/%0d",
                                 out_data, out_words, e.data, e.words);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && out_valid === 1'b0)
               && n < budget) begin
            @(negedge rclk);
            n++;
        end
        checks++;
        if (!(fifo_q.size() == 0 && exp_q.size() == 0 && out_valid === 1'b0)) begin
            errors++;
            $display("FAIL %s_timeout: got fifo=%0d pending=%0d expected 0/0",
                     tag, fifo_q.size(), exp_q.size());
        end
        step();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge rclk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_words !== '0 ||
            rinc !== 1'b0 || seq_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h w=%0d rinc=%b se=%b ec=%0d expected all 0",
                     out_valid, out_data, out_words, rinc, seq_err, err_cnt);
        end
        step();
        rrst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int b0 = beats;
        seq_chk_en = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) push_word(WIDTH'(i));
        wait_idle(60, "basic");
        checks++;
        if (beats - b0 != 2) begin
            errors++;
            $display("FAIL basic_beats: got %0d expected 2", beats - b0);
        end
        checks++;
        if (seq_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL basic_seq: got se=%b ec=%0d expected 0/0", seq_err, err_cnt);
        end
        seq_chk_en = 1'b0;
        step();
    endtask

    task automatic test_stall();
        int b0 = beats;
        int p0 = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) push_word(WIDTH'(i));
        repeat (25) @(negedge rclk);
        checks++;
        if (pops - p0 != 7 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL stall_pops: got pops=%0d rinc=%b expected 7/0", pops - p0, rinc);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h03020100 || out_words !== OW'(4)) begin
            errors++;
            $display("FAIL stall_head: got v=%b d=%h w=%0d expected 1/03020100/4",
                     out_valid, out_data, out_words);
        end
        step();
        out_ready = 1'b1;
        wait_idle(60, "stall");
        checks++;
        if (beats - b0 != 3) begin
            errors++;
            $display("FAIL stall_beats: got %0d expected 3", beats - b0);
        end
    endtask

    task automatic test_flush();
        int b0 = beats;
        int b1;
        out_ready = 1'b1;
        push_word(8'h10);
        push_word(8'h11);
        push_word(8'h12);
        repeat (8) @(negedge rclk);
        step();
        model_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_idle(20, "flush");
        checks++;
        if (beats - b0 != 1) begin
            errors++;
            $display("FAIL flush_beats: got %0d expected 1", beats - b0);
        end
        b1 = beats;
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (6) @(negedge rclk);
        checks++;
        if (beats != b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got beats=%0d v=%b expected 0/0", beats - b1, out_valid);
        end
        step();
    endtask

    task automatic test_seq();
        logic [WIDTH-1:0] good [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [WIDTH-1:0] bad  [4] = '{8'h05, 8'h06, 8'h09, 8'h0A};
        out_ready  = 1'b1;
        seq_chk_en = 1'b0;
        step();
        seq_chk_en = 1'b1;
        foreach (good[i]) push_word(good[i]);
        wait_idle(40, "seq_wrap");
        checks++;
        if (seq_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL seq_wrap: got se=%b ec=%0d expected 0/0", seq_err, err_cnt);
        end
        seq_chk_en = 1'b0;
        step();
        seq_chk_en = 1'b1;
        foreach (bad[i]) push_word(bad[i]);
        wait_idle(40, "seq_err");
        checks++;
        if (seq_err !== 1'b1 || err_cnt !== CNT_W'(1)) begin
            errors++;
            $display("FAIL seq_err: got se=%b ec=%0d expected 1/1", seq_err, err_cnt);
        end
        seq_chk_en = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int b0;
        int p0 = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_word(WIDTH'(8'h30 + i));
        repeat (15) @(negedge rclk);
        checks++;
        if (pops - p0 != 6 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got pops=%0d v=%b expected 6/1", pops - p0, out_valid);
        end
        step();
        rrst_n = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) push_word(WIDTH'(8'h20 + i));
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_words !== '0 ||
            rinc !== 1'b0 || seq_err !== 1'b0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b d=%h w=%0d rinc=%b se=%b ec=%0d expected all 0",
                     out_valid, out_data, out_words, rinc, seq_err, err_cnt);
        end
        step();
        b0 = beats;
        rrst_n    = 1'b1;
        out_ready = 1'b1;
        wait_idle(40, "mid_after");
        checks++;
        if (beats - b0 != 1) begin
            errors++;
            $display("FAIL mid_beats: got %0d expected 1", beats - b0);
        end
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        int p0 = pops;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_word(WIDTH'(8'h40 + i));
        repeat (15) @(negedge rclk);
        checks++;
        if (pops - p0 != 7 || rinc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_stall: got pops=%0d rinc=%b expected 7/0", pops - p0, rinc);
        end
        step();
        out_ready = 1'b1;
        @(negedge rclk);
        @(negedge rclk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h47464544) begin
            errors++;
            $display("FAIL b2b_load: got v=%b d=%h expected 1/47464544", out_valid, out_data);
        end
        step();
        wait_idle(20, "b2b");
        checks++;
        if (beats - b0 != 2) begin
            errors++;
            $display("FAIL b2b_beats: got %0d expected 2", beats - b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        refresh();
        test_reset();
        test_basic();
        test_stall();
        test_flush();
        test_seq();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
